// File: rtl/wbutxarb.sv
// Two-source UART-TX arbiter: a command channel (tag bit 1) and a console
// (tag bit 0) share one byte stream, with a burst limit and a cmd-port gate.
module wbutxarb #(
  parameter int unsigned MAXBURST     = 8,
  parameter bit          CMD_OFF_INIT = 1'b1,
  parameter int unsigned LGIDLE       = 0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx_cmd_stb,
  input  logic       i_cmd_stb,
  input  logic [6:0] i_cmd_data,
  output logic       o_cmd_busy,
  input  logic       i_con_stb,
  input  logic [6:0] i_con_data,
  output logic       o_con_busy,
  output logic       o_tx_stb,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_busy,
  output logic       o_cmd_active,
  output logic       o_drop_stb
);

  localparam int unsigned IW       = (LGIDLE > 0) ? LGIDLE : 1;
  localparam bit          USE_IDLE = (LGIDLE > 0) && CMD_OFF_INIT;
  localparam logic [7:0]  MAXB     = 8'(MAXBURST);

  logic          cmd_full;
  logic [6:0]    cmd_byte;
  logic          con_full;
  logic [6:0]    con_byte;
  logic [7:0]    burst;
  logic [IW-1:0] idle_cnt;

  logic slot_free;
  logic cmd_drop;
  logic grant_cmd;
  logic grant_con;
  logic idle_done;

  assign o_cmd_busy = cmd_full;
  assign o_con_busy = con_full;

  always_comb begin
    slot_free = !o_tx_stb || !i_tx_busy;
    // An inactive port discards its byte whether or not the output slot is free.
    cmd_drop  = cmd_full && !o_cmd_active;
    grant_cmd = slot_free && cmd_full && o_cmd_active &&
                (!con_full || (burst < MAXB));
    grant_con = slot_free && con_full && !grant_cmd;
    idle_done = USE_IDLE && o_cmd_active && !i_rx_cmd_stb && (&idle_cnt);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cmd_full     <= 1'b0;
      cmd_byte     <= '0;
      con_full     <= 1'b0;
      con_byte     <= '0;
      o_tx_stb     <= 1'b0;
      o_tx_data    <= '0;
      burst        <= '0;
      idle_cnt     <= '0;
      o_drop_stb   <= 1'b0;
      o_cmd_active <= !CMD_OFF_INIT;
    end else begin
      o_drop_stb <= cmd_drop;

      if (grant_cmd || cmd_drop)
        cmd_full <= 1'b0;
      else if (i_cmd_stb && !cmd_full) begin
        cmd_full <= 1'b1;
        cmd_byte <= i_cmd_data;
      end

      if (grant_con)
        con_full <= 1'b0;
      else if (i_con_stb && !con_full) begin
        con_full <= 1'b1;
        con_byte <= i_con_data;
      end

      if (grant_cmd) begin
        o_tx_stb  <= 1'b1;
        o_tx_data <= {1'b1, cmd_byte};
      end else if (grant_con) begin
        o_tx_stb  <= 1'b1;
        o_tx_data <= {1'b0, con_byte};
      end else if (!i_tx_busy)
        o_tx_stb  <= 1'b0;

      // Burst only counts cmd grants that overtook a waiting console byte.
      if (!con_full)
        burst <= '0;
      else if (grant_cmd)
        burst <= burst + 8'd1;
      else if (grant_con)
        burst <= '0;

      if (!CMD_OFF_INIT)
        o_cmd_active <= 1'b1;
      else if (i_rx_cmd_stb)
        o_cmd_active <= 1'b1;
      else if (idle_done)
        o_cmd_active <= 1'b0;

      if (!USE_IDLE || i_rx_cmd_stb || idle_done)
        idle_cnt <= '0;
      else if (o_cmd_active)
        idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wbutxarb.sv
// Directed bench for wbutxarb: queue-driven sources, a paced TX sink and
// hand-computed byte sequences.
module tb_wbutxarb;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rx_cmd_stb = 1'b0;
  logic       i_cmd_stb = 1'b0;
  logic [6:0] i_cmd_data = '0;
  logic       o_cmd_busy;
  logic       i_con_stb = 1'b0;
  logic [6:0] i_con_data = '0;
  logic       o_con_busy;
  logic       o_tx_stb;
  logic [7:0] o_tx_data;
  logic       i_tx_busy = 1'b0;
  logic       o_cmd_active;
  logic       o_drop_stb;

  wbutxarb #(.MAXBURST(8), .CMD_OFF_INIT(1'b1), .LGIDLE(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_cmd_stb(i_rx_cmd_stb),
    .i_cmd_stb(i_cmd_stb), .i_cmd_data(i_cmd_data), .o_cmd_busy(o_cmd_busy),
    .i_con_stb(i_con_stb), .i_con_data(i_con_data), .o_con_busy(o_con_busy),
    .o_tx_stb(o_tx_stb), .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy),
    .o_cmd_active(o_cmd_active), .o_drop_stb(o_drop_stb)
  );

  always #5 i_clk = ~i_clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [6:0] cmd_q[$];
  logic [6:0] con_q[$];
  logic [7:0] tx_log[$];
  int         drops = 0;
  bit         slow = 1'b0;
  logic       hold_busy = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: observe at the falling edge, drive just after the rising edge.
  // In slow mode the sink stalls each new byte for exactly one cycle.
  task automatic tick();
    logic cmd_acc, con_acc, busy_nx;
    @(negedge i_clk);
    if (o_tx_stb && !i_tx_busy) tx_log.push_back(o_tx_data);
    if (o_drop_stb) drops++;
    cmd_acc = i_cmd_stb && !o_cmd_busy && !i_reset;
    con_acc = i_con_stb && !o_con_busy && !i_reset;
    busy_nx = slow ? !(o_tx_stb && i_tx_busy) : hold_busy;
    @(posedge i_clk);
    #1;
    if (cmd_acc && cmd_q.size() > 0) void'(cmd_q.pop_front());
    if (con_acc && con_q.size() > 0) void'(con_q.pop_front());
    i_cmd_stb  = (cmd_q.size() > 0);
    i_cmd_data = (cmd_q.size() > 0) ? cmd_q[0] : 7'h0;
    i_con_stb  = (con_q.size() > 0);
    i_con_data = (con_q.size() > 0) ? con_q[0] : 7'h0;
    i_tx_busy  = busy_nx;
  endtask

  initial begin
    int n;
    int bad_cycles;
    int drops0;
    logic [7:0] exp3[11];

    // Reset state
    repeat (3) tick();
    i_reset = 1'b0;
    check_val("rst_tx_stb", 32'(o_tx_stb), 0);
    check_val("rst_tx_data", 32'(o_tx_data), 0);
    check_val("rst_cmd_busy", 32'(o_cmd_busy), 0);
    check_val("rst_con_busy", 32'(o_con_busy), 0);
    check_val("rst_active", 32'(o_cmd_active), 0);
    check_val("rst_drop", 32'(o_drop_stb), 0);

    // Inactive port drops the cmd byte; console passes through
    cmd_q.push_back(7'h41);
    repeat (6) tick();
    check_val("t1_drops", 32'(drops), 1);
    check_val("t1_no_tx", 32'(tx_log.size()), 0);
    con_q.push_back(7'h41);
    repeat (6) tick();
    check_val("t1_con_cnt", 32'(tx_log.size()), 1);
    if (tx_log.size() > 0) check_val("t1_con_byte", 32'(tx_log[0]), 32'h41);

    // Activation, then simultaneous cmd/console: cmd wins
    tx_log.delete();
    i_rx_cmd_stb = 1'b1;
    tick();
    i_rx_cmd_stb = 1'b0;
    cmd_q.push_back(7'h55);
    con_q.push_back(7'h22);
    repeat (6) tick();
    check_val("t2_cnt", 32'(tx_log.size()), 2);
    if (tx_log.size() >= 2) begin
      check_val("t2_first", 32'(tx_log[0]), 32'hD5);
      check_val("t2_second", 32'(tx_log[1]), 32'h22);
    end
    i_rx_cmd_stb = 1'b1;

    // Burst limit: 8 cmd bytes, then the waiting console byte, then cmd again
    tx_log.delete();
    slow = 1'b1;
    for (int i = 1; i <= 10; i++) cmd_q.push_back(7'(i));
    con_q.push_back(7'h30);
    for (int i = 0; i < 8; i++) exp3[i] = 8'h80 | 8'(i + 1);
    exp3[8]  = 8'h30;
    exp3[9]  = 8'h89;
    exp3[10] = 8'h8A;
    n = 0;
    while (tx_log.size() < 11 && n < 200) begin
      tick();
      n++;
    end
    check_val("t3_cnt", 32'(tx_log.size()), 11);
    for (int i = 0; i < 11; i++)
      if (i < tx_log.size()) check_val($sformatf("t3_byte%0d", i), 32'(tx_log[i]), 32'(exp3[i]));
    slow = 1'b0;

    // Stalled sink: output held, both holding regs stay full, nothing lost
    repeat (4) tick();
    tx_log.delete();
    hold_busy = 1'b1;
    tick();
    cmd_q.push_back(7'h11);
    cmd_q.push_back(7'h12);
    con_q.push_back(7'h61);
    repeat (4) tick();
    bad_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!(o_tx_stb === 1'b1 && o_tx_data === 8'h91 && o_cmd_busy === 1'b1 && o_con_busy === 1'b1))
        bad_cycles++;
    end
    check_val("t4_stable", 32'(bad_cycles), 0);
    check_val("t4_no_xfer", 32'(tx_log.size()), 0);
    hold_busy = 1'b0;
    repeat (8) tick();
    check_val("t4_cnt", 32'(tx_log.size()), 3);
    if (tx_log.size() >= 3) begin
      check_val("t4_b0", 32'(tx_log[0]), 32'h91);
      check_val("t4_b1", 32'(tx_log[1]), 32'h92);
      check_val("t4_b2", 32'(tx_log[2]), 32'h61);
    end

    // Idle timeout: 15 increments to all-ones, then deactivate
    tx_log.delete();
    i_rx_cmd_stb = 1'b0;
    check_val("t5_active_start", 32'(o_cmd_active), 1);
    n = 0;
    while (o_cmd_active === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_val("t5_fall_cycles", 32'(n), 16);
    drops0 = drops;
    cmd_q.push_back(7'h77);
    repeat (6) tick();
    check_val("t5_drop", 32'(drops - drops0), 1);
    check_val("t5_no_tx", 32'(tx_log.size()), 0);

    // Reset with a byte on the output and both holding regs full
    i_rx_cmd_stb = 1'b1;
    hold_busy = 1'b1;
    tick();
    cmd_q.push_back(7'h01);
    cmd_q.push_back(7'h02);
    con_q.push_back(7'h03);
    repeat (6) tick();
    check_val("t6_pre_stb", 32'(o_tx_stb), 1);
    check_val("t6_pre_full", 32'({o_cmd_busy, o_con_busy}), 3);
    i_reset = 1'b1;
    cmd_q.delete();
    con_q.delete();
    i_cmd_stb = 1'b0;
    i_con_stb = 1'b0;
    i_rx_cmd_stb = 1'b0;
    tick();
    check_val("t6_tx_stb", 32'(o_tx_stb), 0);
    check_val("t6_tx_data", 32'(o_tx_data), 0);
    check_val("t6_busy", 32'({o_cmd_busy, o_con_busy}), 0);
    check_val("t6_active", 32'(o_cmd_active), 0);
    check_val("t6_drop", 32'(o_drop_stb), 0);
    i_reset = 1'b0;
    hold_busy = 1'b0;
    tx_log.delete();
    repeat (10) tick();
    check_val("t6_no_stale", 32'(tx_log.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
